// File: rtl/cim_wb_arbiter.sv
// cim_wb_arbiter: buffers 6x6 output tiles from two PEs, grants them round-robin
// to the single CIM SRAM port and performs read-modify-write accumulation of
// partial sums. New grants are held off while the scan path owns the SRAM.
module cim_wb_arbiter #(
   parameter int FIFO_DEPTH = 2,
   parameter int RD_LAT     = 1,
   parameter int ELEM_W     = 12
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [36*ELEM_W-1:0]  pe1_tile_i,
   input  logic [7:0]            pe1_od_i,
   input  logic [7:0]            pe1_addr_i,
   input  logic                  pe1_first_i,
   input  logic                  pe1_valid_i,
   output logic                  pe1_ready_o,
   input  logic [36*ELEM_W-1:0]  pe2_tile_i,
   input  logic [7:0]            pe2_od_i,
   input  logic [7:0]            pe2_addr_i,
   input  logic                  pe2_first_i,
   input  logic                  pe2_valid_i,
   output logic                  pe2_ready_o,
   input  logic                  scan_busy_i,
   output logic                  sram_ren_o,
   output logic                  sram_wen_o,
   output logic [7:0]            sram_addr_o,
   output logic [7:0]            sram_od_o,
   output logic [511:0]          sram_wdata_o,
   input  logic [511:0]          sram_rdata_i,
   output logic                  busy_o,
   output logic [15:0]           wr_count_o
);
   localparam int TILE_W = 36 * ELEM_W;
   localparam int PAD_W  = 512 - TILE_W;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   typedef struct packed {
      logic [TILE_W-1:0] tile;
      logic [7:0]        od;
      logic [7:0]        addr;
      logic              first;
   } entry_t;

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WAIT, S_WR} state_t;

   entry_t            in_ent [2];
   logic [1:0]        in_vld;
   entry_t            mem_q  [2][FIFO_DEPTH];
   logic [PTR_W-1:0]  wp_q   [2];
   logic [PTR_W-1:0]  rp_q   [2];
   logic [CNT_W-1:0]  cnt_q  [2];
   logic [1:0]        full, empty, push, pop;
   entry_t            head   [2];

   state_t            state_q;
   logic              pref_q;
   logic [LAT_W-1:0]  wcnt_q;
   logic              ren_q, wen_q;
   logic [7:0]        addr_q, od_q;
   logic [511:0]      wdata_q;
   logic [15:0]       wr_count_q;

   logic              grant_vld, grant_sel;
   entry_t            grant_ent;
   logic              rdata_unused;

   // Signed element add, clamped to the representable range on overflow
   function automatic logic signed [ELEM_W-1:0] sat_add(input logic signed [ELEM_W-1:0] a,
                                                        input logic signed [ELEM_W-1:0] b);
      logic signed [ELEM_W:0] s;
      s = {a[ELEM_W-1], a} + {b[ELEM_W-1], b};
      if (s[ELEM_W] != s[ELEM_W-1])
         return s[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
      return s[ELEM_W-1:0];
   endfunction

   // Element-wise saturating accumulation of a whole 6x6 tile
   function automatic logic [TILE_W-1:0] tile_sat_add(input logic [TILE_W-1:0] a,
                                                      input logic [TILE_W-1:0] b);
      logic [TILE_W-1:0] r;
      r = '0;
      for (int k = 0; k < 36; k++)
         r[k*ELEM_W +: ELEM_W] = sat_add(a[k*ELEM_W +: ELEM_W], b[k*ELEM_W +: ELEM_W]);
      return r;
   endfunction

   // Bundle the two PE request interfaces so the FIFOs can be handled in a loop
   always_comb begin
      in_ent[0] = '{tile: pe1_tile_i, od: pe1_od_i, addr: pe1_addr_i, first: pe1_first_i};
      in_ent[1] = '{tile: pe2_tile_i, od: pe2_od_i, addr: pe2_addr_i, first: pe2_first_i};
      in_vld    = {pe2_valid_i, pe1_valid_i};
      for (int p = 0; p < 2; p++) begin
         full[p]  = (cnt_q[p] == CNT_W'(FIFO_DEPTH));
         empty[p] = (cnt_q[p] == '0);
         head[p]  = mem_q[p][rp_q[p]];
         push[p]  = in_vld[p] && !full[p] && !reset;
      end
   end

   // Round-robin pick among non-empty FIFOs; grants only from IDLE with scan idle
   always_comb begin
      grant_vld = 1'b0;
      grant_sel = 1'b0;
      if (state_q == S_IDLE && !scan_busy_i) begin
         if (!empty[0] && !empty[1]) begin
            grant_vld = 1'b1;
            grant_sel = pref_q;
         end else if (!empty[0]) begin
            grant_vld = 1'b1;
            grant_sel = 1'b0;
         end else if (!empty[1]) begin
            grant_vld = 1'b1;
            grant_sel = 1'b1;
         end
      end
      grant_ent = grant_sel ? head[1] : head[0];
      pop[0]    = grant_vld && !grant_sel;
      pop[1]    = grant_vld && grant_sel;
   end

   // FIFO storage: data is written on push only, never cleared
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++)
         if (push[p]) mem_q[p][wp_q[p]] <= in_ent[p];
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (reset) begin
            wp_q[p]  <= '0;
            rp_q[p]  <= '0;
            cnt_q[p] <= '0;
         end else begin
            if (push[p]) wp_q[p] <= wp_q[p] + PTR_W'(1);
            if (pop[p])  rp_q[p] <= rp_q[p] + PTR_W'(1);
            cnt_q[p] <= cnt_q[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
         end
      end
   end

   // Sequencer: one SRAM op in flight; the popped tile waits in wdata_q and is
   // either written directly or used as the addend once the old word returns
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         pref_q     <= 1'b0;
         wcnt_q     <= '0;
         ren_q      <= 1'b0;
         wen_q      <= 1'b0;
         addr_q     <= '0;
         od_q       <= '0;
         wdata_q    <= '0;
         wr_count_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (grant_vld) begin
                  pref_q  <= ~grant_sel;
                  addr_q  <= grant_ent.addr;
                  od_q    <= grant_ent.od;
                  wdata_q <= {{PAD_W{1'b0}}, grant_ent.tile};
                  if (grant_ent.first) begin
                     wen_q   <= 1'b1;
                     state_q <= S_WR;
                  end else begin
                     ren_q   <= 1'b1;
                     state_q <= S_RD;
                  end
               end
            end
            S_RD: begin
               ren_q   <= 1'b0;
               wcnt_q  <= '0;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               if (wcnt_q == LAT_W'(RD_LAT - 1)) begin
                  wdata_q <= {{PAD_W{1'b0}},
                              tile_sat_add(wdata_q[TILE_W-1:0], sram_rdata_i[TILE_W-1:0])};
                  wen_q   <= 1'b1;
                  state_q <= S_WR;
               end else begin
                  wcnt_q <= wcnt_q + LAT_W'(1);
               end
            end
            S_WR: begin
               wen_q      <= 1'b0;
               wr_count_q <= wr_count_q + 16'd1;
               state_q    <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rdata_unused = ^sram_rdata_i[511:TILE_W];

   assign pe1_ready_o  = !reset && !full[0];
   assign pe2_ready_o  = !reset && !full[1];
   assign sram_ren_o   = ren_q;
   assign sram_wen_o   = wen_q;
   assign sram_addr_o  = addr_q;
   assign sram_od_o    = od_q;
   assign sram_wdata_o = wdata_q;
   assign wr_count_o   = wr_count_q;
   assign busy_o       = (state_q != S_IDLE) || !empty[0] || !empty[1];

endmodule

// File: tb/tb_cim_wb_arbiter.sv
// tb_cim_wb_arbiter: directed vectors plus hand sequences for cim_wb_arbiter,
// with a one-cycle-latency SRAM model behind the port.
module tb_cim_wb_arbiter;
   logic          clk = 1'b0;
   logic          reset;
   logic [431:0]  pe1_tile, pe2_tile;
   logic [7:0]    pe1_od, pe1_addr, pe2_od, pe2_addr;
   logic          pe1_first, pe1_valid, pe2_first, pe2_valid;
   logic          pe1_ready, pe2_ready;
   logic          scan_busy;
   logic          sram_ren, sram_wen;
   logic [7:0]    sram_addr, sram_od;
   logic [511:0]  sram_wdata, sram_rdata;
   logic          busy;
   logic [15:0]   wr_count;

   int n_chk  = 0;
   int n_fail = 0;
   int wen_total = 0;
   int ren_total = 0;
   logic [7:0] wen_addr_q [$];

   logic [511:0] sram_mem [256];
   logic [511:0] rd_pipe;

   typedef struct {
      logic [11:0] a;
      logic [11:0] b;
      logic [11:0] e;
      logic [7:0]  addr;
   } vec_t;
   vec_t vt [10];

   always #5 clk = ~clk;

   cim_wb_arbiter #(.FIFO_DEPTH(2), .RD_LAT(1), .ELEM_W(12)) dut (
      .clk(clk), .reset(reset),
      .pe1_tile_i(pe1_tile), .pe1_od_i(pe1_od), .pe1_addr_i(pe1_addr),
      .pe1_first_i(pe1_first), .pe1_valid_i(pe1_valid), .pe1_ready_o(pe1_ready),
      .pe2_tile_i(pe2_tile), .pe2_od_i(pe2_od), .pe2_addr_i(pe2_addr),
      .pe2_first_i(pe2_first), .pe2_valid_i(pe2_valid), .pe2_ready_o(pe2_ready),
      .scan_busy_i(scan_busy),
      .sram_ren_o(sram_ren), .sram_wen_o(sram_wen), .sram_addr_o(sram_addr),
      .sram_od_o(sram_od), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
      .busy_o(busy), .wr_count_o(wr_count)
   );

   // SRAM model: read data valid one cycle after the read strobe
   always @(posedge clk) begin
      if (sram_ren) rd_pipe <= sram_mem[sram_addr];
      if (sram_wen) sram_mem[sram_addr] <= sram_wdata;
   end
   assign sram_rdata = rd_pipe;

   // Strobe monitor
   always @(negedge clk) begin
      if (sram_wen) begin
         wen_total <= wen_total + 1;
         wen_addr_q.push_back(sram_addr);
      end
      if (sram_ren) ren_total <= ren_total + 1;
   end

   function automatic logic [431:0] fill(input logic [11:0] v);
      logic [431:0] r;
      for (int k = 0; k < 36; k++) r[k*12 +: 12] = v;
      return r;
   endfunction

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive(input int p, input logic v, input logic [7:0] a, input logic [7:0] o,
                        input logic f, input logic [431:0] t);
      if (p == 1) begin
         pe1_valid = v; pe1_addr = a; pe1_od = o; pe1_first = f; pe1_tile = t;
      end else begin
         pe2_valid = v; pe2_addr = a; pe2_od = o; pe2_first = f; pe2_tile = t;
      end
   endtask

   task automatic push_one(input int p, input logic [7:0] a, input logic [7:0] o,
                           input logic f, input logic [431:0] t);
      drive(p, 1'b1, a, o, f, t);
      step(1);
      drive(p, 1'b0, a, o, f, t);
   endtask

   task automatic wait_wen(input string name, output logic [7:0] ad, output logic [7:0] od,
                           output logic [511:0] wd);
      ad = '0; od = '0; wd = '0;
      for (int k = 0; k < 30; k++) begin
         if (sram_wen) break;
         step(1);
      end
      if (!sram_wen) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: timeout waiting for wen", name);
      end else begin
         ad = sram_addr; od = sram_od; wd = sram_wdata;
      end
      step(1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      scan_busy = 1'b0;
      drive(1, 1'b0, 8'h00, 8'h00, 1'b0, '0);
      drive(2, 1'b0, 8'h00, 8'h00, 1'b0, '0);
      step(2);
      reset = 1'b0;
      step(1);
   endtask

   initial begin
      logic [7:0]   ad, od;
      logic [511:0] wd, exp_w;
      int           sent, snap_w, snap_r;
      logic [7:0]   exp_a [4];

      vt[0] = '{12'h7F0, 12'h020, 12'h7FF, 8'd12};
      vt[1] = '{12'h810, 12'hFE0, 12'h800, 8'd13};
      vt[2] = '{12'h000, 12'hFFF, 12'hFFF, 8'd14};
      vt[3] = '{12'h7FF, 12'h801, 12'h000, 8'd15};
      vt[4] = '{12'h400, 12'h400, 12'h7FF, 8'd16};
      vt[5] = '{12'hC00, 12'hC00, 12'h800, 8'd17};
      vt[6] = '{12'h123, 12'h001, 12'h124, 8'd18};
      vt[7] = '{12'h800, 12'h7FF, 12'hFFF, 8'd19};
      vt[8] = '{12'h7FF, 12'h001, 12'h7FF, 8'd20};
      vt[9] = '{12'h800, 12'hFFF, 12'h800, 8'd21};

      // Reset state
      reset = 1'b1;
      scan_busy = 1'b0;
      drive(1, 1'b0, 8'h00, 8'h00, 1'b0, '0);
      drive(2, 1'b0, 8'h00, 8'h00, 1'b0, '0);
      step(2);
      chk("rst_ready1", pe1_ready, 1'b0);
      chk("rst_ready2", pe2_ready, 1'b0);
      chk("rst_wen", sram_wen, 1'b0);
      chk("rst_ren", sram_ren, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_wrcnt", wr_count, 16'd0);
      chk("rst_wdata", sram_wdata, 512'd0);
      reset = 1'b0;
      step(1);
      chk("post_rst_ready1", pe1_ready, 1'b1);
      chk("post_rst_ready2", pe2_ready, 1'b1);

      // Overwrite latency: wen one cycle after the pop cycle
      drive(1, 1'b1, 8'd3, 8'hA1, 1'b1, fill(12'h0CC));
      step(1);
      drive(1, 1'b0, 8'd3, 8'hA1, 1'b1, fill(12'h0CC));
      chk("ow_pop_wen", sram_wen, 1'b0);
      chk("ow_pop_busy", busy, 1'b1);
      step(1);
      chk("ow_wen", sram_wen, 1'b1);
      chk("ow_addr", sram_addr, 8'd3);
      chk("ow_od", sram_od, 8'hA1);
      chk("ow_wdata", sram_wdata, {80'd0, fill(12'h0CC)});
      step(1);
      chk("ow_wen_off", sram_wen, 1'b0);
      chk("ow_wrcnt", wr_count, 16'd1);
      chk("ow_idle_busy", busy, 1'b0);

      // Round-robin with simultaneous pushes
      do_reset();
      wen_addr_q.delete();
      sent = 0;
      for (int c = 0; c < 60; c++) begin
         if (sent < 4 && pe1_ready && pe2_ready) begin
            drive(1, 1'b1, 8'd3, 8'h01, 1'b1, fill(12'h011));
            drive(2, 1'b1, 8'd4, 8'h02, 1'b1, fill(12'h022));
            sent++;
         end else begin
            drive(1, 1'b0, 8'd3, 8'h01, 1'b1, fill(12'h011));
            drive(2, 1'b0, 8'd4, 8'h02, 1'b1, fill(12'h022));
         end
         step(1);
      end
      chk("rr_wrcnt", wr_count, 16'd8);
      chk("rr_nwrites", wen_addr_q.size(), 8);
      for (int k = 0; k < 8; k++)
         chk($sformatf("rr_addr%0d", k), (k < wen_addr_q.size()) ? wen_addr_q[k] : 8'hFF,
             (k % 2 == 0) ? 8'd3 : 8'd4);

      // RMW latency: store 0x100 then accumulate 0x050 at addr 5
      push_one(1, 8'd5, 8'h05, 1'b1, fill(12'h100));
      wait_wen("rmw_init", ad, od, wd);
      drive(1, 1'b1, 8'd5, 8'h5A, 1'b0, fill(12'h050));
      step(1);
      drive(1, 1'b0, 8'd5, 8'h5A, 1'b0, fill(12'h050));
      chk("rmw_pop_ren", sram_ren, 1'b0);
      step(1);
      chk("rmw_ren", sram_ren, 1'b1);
      chk("rmw_ren_addr", sram_addr, 8'd5);
      step(1);
      chk("rmw_wait_ren", sram_ren, 1'b0);
      chk("rmw_wait_wen", sram_wen, 1'b0);
      step(1);
      chk("rmw_wen", sram_wen, 1'b1);
      chk("rmw_wen_addr", sram_addr, 8'd5);
      chk("rmw_od", sram_od, 8'h5A);
      chk("rmw_wdata", sram_wdata, {80'd0, fill(12'h150)});
      step(1);

      // Saturation vectors
      for (int i = 0; i < 10; i++) begin
         push_one((i % 2) + 1, vt[i].addr, 8'(i), 1'b1, fill(vt[i].a));
         wait_wen($sformatf("vec%0d_init", i), ad, od, wd);
         push_one((i % 2) + 1, vt[i].addr, 8'(i), 1'b0, fill(vt[i].b));
         wait_wen($sformatf("vec%0d_acc", i), ad, od, wd);
         chk($sformatf("vec%0d_addr", i), ad, vt[i].addr);
         chk($sformatf("vec%0d_data", i), wd, {80'd0, fill(vt[i].e)});
      end

      // Per-element accumulation: element k = k*50 + k*10, clamped at +2047
      begin
         logic [431:0] ta, tb;
         exp_w = '0;
         for (int k = 0; k < 36; k++) begin
            int s;
            ta[k*12 +: 12] = 12'(k * 50);
            tb[k*12 +: 12] = 12'(k * 10);
            s = k * 60;
            if (s > 2047) s = 2047;
            exp_w[k*12 +: 12] = 12'(s);
         end
         push_one(2, 8'd9, 8'h33, 1'b1, ta);
         wait_wen("elem_init", ad, od, wd);
         push_one(2, 8'd9, 8'h33, 1'b0, tb);
         wait_wen("elem_acc", ad, od, wd);
         chk("elem_od", od, 8'h33);
         chk("elem_data", wd, exp_w);
      end

      // Scan busy holds off grants while FIFOs fill
      do_reset();
      wen_addr_q.delete();
      scan_busy = 1'b1;
      drive(1, 1'b1, 8'd10, 8'h00, 1'b1, fill(12'h00A));
      drive(2, 1'b1, 8'd20, 8'h00, 1'b1, fill(12'h014));
      step(1);
      drive(1, 1'b1, 8'd11, 8'h00, 1'b1, fill(12'h00B));
      drive(2, 1'b1, 8'd21, 8'h00, 1'b1, fill(12'h015));
      step(1);
      drive(1, 1'b0, 8'd11, 8'h00, 1'b1, fill(12'h00B));
      drive(2, 1'b0, 8'd21, 8'h00, 1'b1, fill(12'h015));
      chk("scan_ready1", pe1_ready, 1'b0);
      chk("scan_ready2", pe2_ready, 1'b0);
      chk("scan_busy_o", busy, 1'b1);
      snap_w = wen_total; snap_r = ren_total;
      step(10);
      chk("scan_no_strobe", wen_total + ren_total, snap_w + snap_r);
      scan_busy = 1'b0;
      step(20);
      chk("scan_drain_cnt", wr_count, 16'd4);
      exp_a = '{8'd10, 8'd20, 8'd11, 8'd21};
      for (int k = 0; k < 4; k++)
         chk($sformatf("scan_addr%0d", k), (k < wen_addr_q.size()) ? wen_addr_q[k] : 8'hFF,
             exp_a[k]);
      chk("scan_ready_after", pe1_ready, 1'b1);

      // Scan asserted mid-op: in-flight RMW completes, queued entry waits
      push_one(1, 8'd20, 8'h00, 1'b1, fill(12'h100));
      wait_wen("mid_init", ad, od, wd);
      drive(1, 1'b1, 8'd20, 8'h00, 1'b0, fill(12'h001));
      step(1);
      drive(1, 1'b1, 8'd6, 8'h00, 1'b1, fill(12'h066));
      step(1);
      drive(1, 1'b0, 8'd6, 8'h00, 1'b1, fill(12'h066));
      scan_busy = 1'b1;
      step(2);
      chk("mid_wen", sram_wen, 1'b1);
      chk("mid_wdata", sram_wdata, {80'd0, fill(12'h101)});
      step(1);
      snap_w = wen_total; snap_r = ren_total;
      step(10);
      chk("mid_held", wen_total + ren_total, snap_w + snap_r);
      chk("mid_busy", busy, 1'b1);
      scan_busy = 1'b0;
      wait_wen("mid_resume", ad, od, wd);
      chk("mid_resume_addr", ad, 8'd6);

      // Reset during WAIT aborts the op and empties the FIFOs
      drive(1, 1'b1, 8'd20, 8'h00, 1'b0, fill(12'h001));
      step(1);
      drive(1, 1'b0, 8'd20, 8'h00, 1'b0, fill(12'h001));
      drive(2, 1'b1, 8'd7, 8'h00, 1'b1, fill(12'h077));
      step(1);
      drive(2, 1'b0, 8'd7, 8'h00, 1'b1, fill(12'h077));
      chk("rw_ren", sram_ren, 1'b1);
      step(1);
      reset = 1'b1;
      step(1);
      chk("rw_wen", sram_wen, 1'b0);
      chk("rw_ren_off", sram_ren, 1'b0);
      chk("rw_busy", busy, 1'b0);
      chk("rw_wrcnt", wr_count, 16'd0);
      chk("rw_ready", pe1_ready, 1'b0);
      reset = 1'b0;
      step(1);
      chk("rw_ready_back", pe2_ready, 1'b1);
      snap_w = wen_total; snap_r = ren_total;
      step(10);
      chk("rw_quiet", wen_total + ren_total, snap_w + snap_r);
      chk("rw_idle_busy", busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
